// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: round-robin arbiter between N L1 miss channels and one shared
// L2/memory port. One channel owns the memory port at a time; the L2 response
// is routed back only to the owner, and a new grant may follow on the response
// edge without an idle cycle. A sticky watchdog flags transactions that hang.
//
// Handshake: a channel raises req_read or req_write and holds it, together with
// its address and write line, until the cycle in which its req_resp bit is high.
// It drops the request in the following cycle. Dropping the request while
// granted and before the response aborts the transaction. mem_resp is a
// single-cycle completion pulse from L2 and is only meaningful while busy.
module l2_rr_arbiter #(
    parameter int N_CH     = 2,
    parameter int S_OFFSET = 5,
    parameter int S_LINE   = 8 * 2**S_OFFSET,
    parameter int TIMEOUT  = 1024,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req_read,
    input  logic [N_CH-1:0]          req_write,
    input  logic [N_CH*32-1:0]       req_address,
    input  logic [N_CH*S_LINE-1:0]   req_wdata,
    output logic [N_CH-1:0]          req_resp,
    output logic [S_LINE-1:0]        req_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [31:0]              mem_address,
    output logic [S_LINE-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [S_LINE-1:0]        mem_rdata,
    output logic                     busy,
    output logic [CH_W-1:0]          owner,
    output logic                     timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]  OWNER_RST = CH_W'(N_CH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CH_W-1:0]    owner_q;
    logic [CH_W-1:0]    owner_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_next;
    logic               err_q;
    logic               err_next;

    logic [N_CH-1:0]    requesting;
    logic [N_CH-1:0]    owner_onehot;
    logic               sel_read;
    logic               sel_write;
    logic [31:0]        sel_address;
    logic [S_LINE-1:0]  sel_wdata;
    logic               owner_req;

    logic [CH_W:0]      idle_search;
    logic [CH_W:0]      rearb_search;
    logic               idle_found;
    logic [CH_W-1:0]    idle_pick;
    logic               rearb_found;
    logic [CH_W-1:0]    rearb_pick;

    // First candidate after 'last' in circular order; 'last' itself is tried
    // at the very end. Returns {found, index}.
    function automatic logic [CH_W:0] rr_search(
        input logic [N_CH-1:0] cand,
        input logic [CH_W-1:0] last
    );
        logic            found;
        logic [CH_W-1:0] pick;
        int              idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last) + k) % N_CH;
            if (!found && cand[idx[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[CH_W-1:0];
            end
        end
        return {found, pick};
    endfunction

    assign requesting = req_read | req_write;

    // Select the owner's request fields and build its one-hot response mask.
    always_comb begin
        sel_read     = 1'b0;
        sel_write    = 1'b0;
        sel_address  = '0;
        sel_wdata    = '0;
        owner_onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (owner_q == CH_W'(i)) begin
                sel_read        = req_read[i];
                sel_write       = req_write[i];
                sel_address     = req_address[32*i +: 32];
                sel_wdata       = req_wdata[S_LINE*i +: S_LINE];
                owner_onehot[i] = 1'b1;
            end
        end
    end

    assign owner_req = sel_read | sel_write;

    // Two searches: from IDLE every channel competes; on a response edge the
    // current owner is excluded so it cannot be re-granted on that edge.
    always_comb begin
        idle_search  = rr_search(requesting, owner_q);
        rearb_search = rr_search(requesting & ~owner_onehot, owner_q);
        idle_found   = idle_search[CH_W];
        idle_pick    = idle_search[CH_W-1:0];
        rearb_found  = rearb_search[CH_W];
        rearb_pick   = rearb_search[CH_W-1:0];
    end

    // Next-state, watchdog and output decode for the IDLE/BUSY machine.
    always_comb begin
        state_next  = state;
        owner_next  = owner_q;
        cnt_next    = cnt_q;
        err_next    = err_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        req_resp    = '0;
        case (state)
            IDLE: begin
                // Stray mem_resp pulses are ignored here.
                if (idle_found) begin
                    state_next = BUSY;
                    owner_next = idle_pick;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                mem_read    = sel_read;
                mem_write   = sel_write;
                mem_address = sel_address;
                mem_wdata   = sel_wdata;
                if (mem_resp) begin
                    req_resp = owner_onehot;
                    cnt_next = '0;
                    if (rearb_found) begin
                        owner_next = rearb_pick;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    // Saturating count; the flag is set once the limit is held.
                    if (cnt_q == CNT_MAX) begin
                        err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_q + CNT_W'(1);
                    end
                    // Owner withdrew its request: abandon without a response.
                    if (!owner_req) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, owner, watchdog counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_q <= OWNER_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            owner_q <= owner_next;
            cnt_q   <= cnt_next;
            err_q   <= err_next;
        end
    end

    assign req_rdata   = mem_rdata;
    assign busy        = (state == BUSY);
    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule
